mem_port_arbiter: RTL

//  Shares the single-port system mem between two requesters: the core (fetcher/decoder

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (core / loader) in front of the single-port system mem.
// Optional MEM_ARB_ROUND_ROBIN_EN: IDLE tie-break alternates instead of favouring the loader.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic              core_stall,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_din,
  output logic              load_gnt,
  output logic              load_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, CORE, LOAD} state_t;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_ACCESS = CNT_W'(MAX_BURST - 1);

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             core_acc;
  logic             load_acc;
  logic             tie_to_load;

  assign core_gnt   = (state == CORE);
  assign load_gnt   = (state == LOAD);
  assign core_acc   = core_gnt & core_req;
  assign load_acc   = load_gnt & load_req;
  assign core_stall = core_req & ~core_gnt;
  assign mem_we     = (core_acc & core_we) | (load_acc & load_we);
  assign rdata      = mem_dout;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    if (core_gnt) begin
      mem_addr = core_addr;
      mem_din  = core_din;
    end else if (load_gnt) begin
      mem_addr = load_addr;
      mem_din  = load_din;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Tracks the most recent owner; IDLE is always preceded by an owner cycle, so this is current at tie time.
  logic last_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_load <= 1'b1;
    else if (state != IDLE)
      last_load <= (state == LOAD);
  end

  assign tie_to_load = ~last_load;
`else
  assign tie_to_load = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      core_rvalid <= 1'b0;
      load_rvalid <= 1'b0;
    end else begin
      core_rvalid <= core_acc & ~core_we;
      load_rvalid <= load_acc & ~load_we;
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (core_req && load_req)
            state <= tie_to_load ? LOAD : CORE;
          else if (load_req)
            state <= LOAD;
          else if (core_req)
            state <= CORE;
        end
        CORE: begin
          if (!core_req) begin
            burst_cnt <= '0;
            state     <= load_req ? LOAD : IDLE;
          end else if (load_req && burst_cnt == LAST_ACCESS) begin
            burst_cnt <= '0;
            state     <= LOAD;
          end else if (burst_cnt != LAST_ACCESS) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (!load_req) begin
            burst_cnt <= '0;
            state     <= core_req ? CORE : IDLE;
          end else if (core_req && burst_cnt == LAST_ACCESS) begin
            burst_cnt <= '0;
            state     <= CORE;
          end else if (burst_cnt != LAST_ACCESS) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
